// File: rtl/hzd_pkg.sv
// Shared definitions for the hazard scoreboard: pipeline stage encoding,
// default Tnew/Tuse values per instruction class and the saturating
// decrement used to age result-ready counts.
package hzd_pkg;

  // Forward-select / stage encoding (0 = register file, k = stage k)
  localparam logic [1:0] STG_RF = 2'd0;
  localparam logic [1:0] STG_E  = 2'd1;
  localparam logic [1:0] STG_M  = 2'd2;
  localparam logic [1:0] STG_W  = 2'd3;

  // Default Tnew (cycles from decode until the result exists)
  localparam logic [1:0] TNEW_ALU  = 2'd2;
  localparam logic [1:0] TNEW_LOAD = 2'd3;

  // Default Tuse (cycles from decode until the operand is consumed)
  localparam logic [1:0] TUSE_BRANCH = 2'd0;
  localparam logic [1:0] TUSE_ALU    = 2'd1;
  localparam logic [1:0] TUSE_STORE  = 2'd2;

  // Working width of sat_dec; callers size-cast their narrower counts
  localparam int SAT_W = 8;

  // Decrement that sticks at zero
  function automatic logic [SAT_W-1:0] sat_dec(input logic [SAT_W-1:0] v);
    logic [SAT_W-1:0] r;
    if (v == 8'd0) begin
      r = 8'd0;
    end else begin
      r = v - 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hzd_entry.sv
// One scoreboard entry: tracks the youngest in-flight producer of a single
// architectural register (valid, cycles until its result exists, and the
// pipeline stage it currently occupies).
// Optional macro HZD_FWD_EN: when undefined the tnew count is not stored.
module hzd_entry
  import hzd_pkg::*;
#(
  parameter int TW    = 2,
  parameter int DEPTH = 3,
  parameter int SW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          load,
  input  logic [TW-1:0] load_tnew,
  output logic          valid,
  output logic [TW-1:0] tnew,
  output logic [SW-1:0] age
);

  logic          valid_r;
  logic [SW-1:0] age_r;

  // Presence and stage tracking; the producer drops out after leaving W
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_r <= 1'b0;
      age_r   <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      age_r   <= SW'(1);
    end else if (valid_r && (age_r == SW'(DEPTH))) begin
      valid_r <= 1'b0;
      age_r   <= '0;
    end else if (valid_r) begin
      valid_r <= 1'b1;
      age_r   <= age_r + SW'(1);
    end else begin
      valid_r <= valid_r;
      age_r   <= age_r;
    end
  end

`ifdef HZD_FWD_EN
  logic [TW-1:0] tnew_r;

  // Result-ready countdown; the stored value is already one cycle past decode
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      tnew_r <= '0;
    end else if (load) begin
      tnew_r <= TW'(sat_dec(SAT_W'(load_tnew)));
    end else if (valid_r) begin
      tnew_r <= TW'(sat_dec(SAT_W'(tnew_r)));
    end else begin
      tnew_r <= tnew_r;
    end
  end

  assign tnew = tnew_r;
`else
  logic unused_tnew_s;
  assign unused_tnew_s = ^load_tnew;
  assign tnew          = '0;
`endif

  assign valid = valid_r;
  assign age   = age_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: one entry per architectural register
// records the youngest in-flight producer; sources of the decode
// instruction are checked against it to produce a stall and forward selects.
// Optional macro HZD_FWD_EN: enables Tnew/Tuse-based stalling and forwarding;
// without it any in-flight producer of a source stalls decode.
module hazard_scoreboard
  import hzd_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int TW    = 2,
  parameter int NSRC  = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 issue_valid,
  input  logic [AW-1:0]                        issue_dst,
  input  logic [TW-1:0]                        issue_tnew,
  input  logic                                 flush,
  input  logic [NSRC*AW-1:0]                   src_addr,
  input  logic [NSRC*TW-1:0]                   src_tuse,
  output logic                                 stall,
  output logic [NSRC*$clog2(DEPTH+1)-1:0]      fwd_sel
);

  localparam int SW = $clog2(DEPTH+1);

  logic [NREG-1:0]         ent_valid_s;
  logic [NREG-1:0][TW-1:0] ent_tnew_s;
  logic [NREG-1:0][SW-1:0] ent_age_s;
  logic                    issue_s;
  logic                    stall_s;
  logic [NSRC*SW-1:0]      fwd_s;

  // Register 0 is hardwired zero and never has a producer
  assign ent_valid_s[0] = 1'b0;
  assign ent_tnew_s[0]  = '0;
  assign ent_age_s[0]   = '0;

  // A stalled decode instruction does not issue; flush discards it too
  assign issue_s = issue_valid && !stall_s && !flush && (issue_dst != '0);

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    hzd_entry #(
      .TW    (TW),
      .DEPTH (DEPTH),
      .SW    (SW)
    ) u_ent (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .load      (issue_s && (issue_dst == AW'(r))),
      .load_tnew (issue_tnew),
      .valid     (ent_valid_s[r]),
      .tnew      (ent_tnew_s[r]),
      .age       (ent_age_s[r])
    );
  end

  // Per-source hazard and forward-stage lookup against pre-issue state
  always_comb begin
    logic [AW-1:0] src_a_s;
    logic [TW-1:0] src_u_s;
    stall_s = 1'b0;
    fwd_s   = '0;
    src_a_s = '0;
    src_u_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_a_s = src_addr[i*AW +: AW];
      src_u_s = src_tuse[i*TW +: TW];
      if ((src_a_s != '0) && ent_valid_s[src_a_s]) begin
`ifdef HZD_FWD_EN
        if (ent_tnew_s[src_a_s] > src_u_s) begin
          stall_s = 1'b1;
        end else begin
          stall_s = stall_s;
        end
        if (ent_tnew_s[src_a_s] == '0) begin
          fwd_s[i*SW +: SW] = ent_age_s[src_a_s];
        end else begin
          fwd_s[i*SW +: SW] = SW'(STG_RF);
        end
`else
        stall_s = 1'b1;
`endif
      end else begin
        fwd_s[i*SW +: SW] = SW'(STG_RF);
      end
    end
  end

`ifndef HZD_FWD_EN
  logic unused_s;
  assign unused_s = ^{src_tuse, ent_tnew_s};
`endif

  // Outputs are forced quiet while reset is held
  assign stall   = reset ? 1'b0 : stall_s;
  assign fwd_sel = reset ? '0 : fwd_s;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. The reference keeps, per
// register, the cycle of its youngest issue and that issue's Tnew; stage and
// remaining Tnew are derived arithmetically from the elapsed cycles.
module tb_hazard_scoreboard;

  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int TW    = 2;
  localparam int NSRC  = 2;
  localparam int SW    = 2;
  localparam int NONE  = -1000;

  logic                clk = 1'b0;
  logic                reset;
  logic                issue_valid;
  logic [AW-1:0]       issue_dst;
  logic [TW-1:0]       issue_tnew;
  logic                flush;
  logic [NSRC*AW-1:0]  src_addr;
  logic [NSRC*TW-1:0]  src_tuse;
  logic                stall;
  logic [NSRC*SW-1:0]  fwd_sel;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int iss_cyc  [NREG];
  int iss_tnew [NREG];

  hazard_scoreboard #(
    .NREG (NREG), .AW (AW), .DEPTH (DEPTH), .TW (TW), .NSRC (NSRC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_dst   (issue_dst),
    .issue_tnew  (issue_tnew),
    .flush       (flush),
    .src_addr    (src_addr),
    .src_tuse    (src_tuse),
    .stall       (stall),
    .fwd_sel     (fwd_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // One decode cycle: apply inputs, check outputs mid-cycle, advance reference
  task automatic drive_cycle(input logic rst, input logic iv, input int dst, input int itn,
                             input logic fl, input int s0, input int u0, input int s1,
                             input int u1, output logic st_obs);
    int   sa [NSRC];
    int   su [NSRC];
    int   ef [NSRC];
    int   age;
    int   tn;
    logic live;
    logic es;
    sa[0] = s0; sa[1] = s1; su[0] = u0; su[1] = u1;
    reset       = rst;
    issue_valid = iv;
    issue_dst   = AW'(dst);
    issue_tnew  = TW'(itn);
    flush       = fl;
    src_addr    = {AW'(s1), AW'(s0)};
    src_tuse    = {TW'(u1), TW'(u0)};
    @(negedge clk);
    es = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      age  = cyc - iss_cyc[sa[i]];
      live = (sa[i] != 0) && (age >= 1) && (age <= DEPTH);
      tn   = iss_tnew[sa[i]] - age;
      if (tn < 0) tn = 0;
      ef[i] = 0;
`ifdef HZD_FWD_EN
      if (live && (tn > su[i])) es = 1'b1;
      if (live && (tn == 0)) ef[i] = age;
`else
      if (live) es = 1'b1;
`endif
      if (rst) ef[i] = 0;
    end
    if (rst) es = 1'b0;
    st_obs = stall;
    chk("stall", 32'(stall), 32'(es));
    for (int i = 0; i < NSRC; i++) begin
      chk($sformatf("fwd_sel%0d", i), 32'(fwd_sel[i*SW +: SW]), 32'(ef[i]));
    end
    @(posedge clk);
    if (rst || fl) begin
      for (int r = 0; r < NREG; r++) iss_cyc[r] = NONE;
    end else if (iv && !es && (dst != 0)) begin
      iss_cyc[dst]  = cyc;
      iss_tnew[dst] = itn;
    end
    cyc++;
    #1;
  endtask

  initial begin
    logic so;
    int   cnt;
    int   exp_cnt;
    for (int r = 0; r < NREG; r++) begin
      iss_cyc[r]  = NONE;
      iss_tnew[r] = 0;
    end
    // reset state
    repeat (2) drive_cycle(1'b1, 1'b1, 5, 3, 1'b0, 5, 0, 6, 0, so);
    drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 5, 0, 6, 0, so);

    // load-use: $5 tnew=3, consumer tuse=1
    drive_cycle(1'b0, 1'b1, 5, 3, 1'b0, 0, 0, 0, 0, so);
    repeat (4) drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 5, 1, 0, 0, so);

    // ALU forwarding: $8 tnew=2, consumer tuse=1
    drive_cycle(1'b0, 1'b1, 8, 2, 1'b0, 0, 0, 0, 0, so);
    repeat (3) drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 8, 1, 8, 1, so);

    // youngest producer wins
    drive_cycle(1'b0, 1'b1, 3, 1, 1'b0, 0, 0, 0, 0, so);
    drive_cycle(1'b0, 1'b1, 3, 1, 1'b0, 0, 0, 0, 0, so);
    drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 3, 0, 0, 0, so);

    // register zero is never tracked
    drive_cycle(1'b0, 1'b1, 0, 3, 1'b0, 0, 0, 0, 0, so);
    drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0, so);

    // flush, then reset, after issuing $4 tnew=3
    drive_cycle(1'b0, 1'b1, 4, 3, 1'b0, 0, 0, 0, 0, so);
    drive_cycle(1'b0, 1'b0, 0, 0, 1'b1, 4, 0, 0, 0, so);
    drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 4, 0, 0, 0, so);
    drive_cycle(1'b0, 1'b1, 4, 3, 1'b0, 0, 0, 0, 0, so);
    drive_cycle(1'b1, 1'b0, 0, 0, 1'b0, 4, 0, 0, 0, so);
    drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 4, 0, 0, 0, so);

    // same-cycle issue to a register that is also a source
    drive_cycle(1'b0, 1'b1, 9, 3, 1'b0, 0, 0, 0, 0, so);
    drive_cycle(1'b0, 1'b1, 9, 1, 1'b0, 9, 0, 0, 0, so);
    repeat (4) drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 9, 0, 0, 0, so);

    // $7 tnew=1 read with tuse=2: stall-cycle count depends on forwarding
    drive_cycle(1'b0, 1'b1, 7, 1, 1'b0, 0, 0, 0, 0, so);
    cnt = 0;
    repeat (5) begin
      drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 7, 2, 0, 0, so);
      if (so === 1'b1) cnt++;
    end
`ifdef HZD_FWD_EN
    exp_cnt = 0;
`else
    exp_cnt = 3;
`endif
    chk("stall_count_r7", 32'(cnt), 32'(exp_cnt));

    // randomized traffic on a narrow register window to provoke hazards
    repeat (400) begin
      drive_cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 14) == 0),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), so);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
